// File: rtl/trav_arb.sv
// Three-source traversal request arbiter: a private FIFO per source feeding a
// single round-robin-granted output register with downstream back-pressure.
module trav_arb #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ss_to_tarb_valid0,
  input  logic [WIDTH-1:0] ss_to_tarb_data0,
  output logic             ss_to_tarb_stall0,
  input  logic             ss_to_tarb_valid1,
  input  logic [WIDTH-1:0] ss_to_tarb_data1,
  output logic             ss_to_tarb_stall1,
  input  logic             raygen_to_tarb_valid,
  input  logic [WIDTH-1:0] raygen_to_tarb_data,
  output logic             raygen_to_tarb_stall,
  output logic             tarb_to_trav_valid,
  output logic [WIDTH-1:0] tarb_to_trav_data,
  output logic [1:0]       tarb_to_trav_src,
  input  logic             tarb_to_trav_stall,
  output logic             busy
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [2:0]       in_valid;
  logic [WIDTH-1:0] in_data [3];
  logic [2:0]       full;
  logic [2:0]       not_empty;
  logic [2:0]       push;
  logic [2:0]       grant_vec;
  logic [WIDTH-1:0] head [3];

  assign in_valid   = {raygen_to_tarb_valid, ss_to_tarb_valid1, ss_to_tarb_valid0};
  assign in_data[0] = ss_to_tarb_data0;
  assign in_data[1] = ss_to_tarb_data1;
  assign in_data[2] = raygen_to_tarb_data;

  // Stalls come straight from registered occupancy, so a full FIFO never
  // accepts a write in the cycle it is popped.
  assign ss_to_tarb_stall0    = full[0];
  assign ss_to_tarb_stall1    = full[1];
  assign raygen_to_tarb_stall = full[2];

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_fifo
      logic [WIDTH-1:0] mem [DEPTH];
      logic [PW-1:0]    wr_ptr_reg;
      logic [PW-1:0]    rd_ptr_reg;
      logic [CW-1:0]    count_reg;

      assign full[gi]      = (count_reg == CW'(DEPTH));
      assign not_empty[gi] = (count_reg != '0);
      assign push[gi]      = in_valid[gi] & ~full[gi];
      assign head[gi]      = mem[rd_ptr_reg];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          count_reg  <= '0;
        end else begin
          if (push[gi]) wr_ptr_reg <= wr_ptr_reg + PW'(1);
          if (grant_vec[gi]) rd_ptr_reg <= rd_ptr_reg + PW'(1);
          case ({push[gi], grant_vec[gi]})
            2'b10:   count_reg <= count_reg + CW'(1);
            2'b01:   count_reg <= count_reg - CW'(1);
            default: count_reg <= count_reg;
          endcase
        end
      end

      always_ff @(posedge clk) begin
        if (push[gi]) mem[wr_ptr_reg] <= in_data[gi];
      end
    end
  endgenerate

  logic [1:0] rr_reg;
  logic [1:0] rr_next;
  logic [1:0] rr_eff;
  logic [1:0] order [3];
  logic       can_load;
  logic       grant_any;
  logic [1:0] grant_idx;

  assign can_load = ~tarb_to_trav_valid | ~tarb_to_trav_stall;

  always_comb begin
    grant_vec = '0;
    grant_any = 1'b0;
    grant_idx = 2'd0;
    rr_eff    = (rr_reg == 2'd3) ? 2'd0 : rr_reg;
    order[0]  = rr_eff;
    order[1]  = (rr_eff == 2'd2) ? 2'd0 : rr_eff + 2'd1;
    order[2]  = (rr_eff == 2'd0) ? 2'd2 : rr_eff - 2'd1;
    if (can_load) begin
      for (int k = 0; k < 3; k++) begin
        if (!grant_any && not_empty[order[k]]) begin
          grant_any            = 1'b1;
          grant_idx            = order[k];
          grant_vec[order[k]]  = 1'b1;
        end
      end
    end
    rr_next = rr_reg;
    if (grant_any) rr_next = (grant_idx == 2'd2) ? 2'd0 : grant_idx + 2'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_reg             <= 2'd0;
      tarb_to_trav_valid <= 1'b0;
      tarb_to_trav_data  <= '0;
      tarb_to_trav_src   <= 2'd0;
    end else begin
      rr_reg <= rr_next;
      if (can_load) begin
        tarb_to_trav_valid <= grant_any;
        if (grant_any) begin
          tarb_to_trav_data <= head[grant_idx];
          tarb_to_trav_src  <= grant_idx;
        end
      end
    end
  end

  assign busy = (|not_empty) | tarb_to_trav_valid;

endmodule

// File: tb/tb_trav_arb.sv
// Directed bench for trav_arb: hand-computed expectations checked with
// immediate assertions, one directed step sequence.
module tb_trav_arb;

  localparam int WIDTH = 96;
  localparam int DEPTH = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [2:0]       vin = 3'b000;
  logic [WIDTH-1:0] din [3];
  logic [2:0]       stall_o;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       out_src;
  logic             down_stall = 1'b0;
  logic             busy;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  trav_arb #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .ss_to_tarb_valid0    (vin[0]),
    .ss_to_tarb_data0     (din[0]),
    .ss_to_tarb_stall0    (stall_o[0]),
    .ss_to_tarb_valid1    (vin[1]),
    .ss_to_tarb_data1     (din[1]),
    .ss_to_tarb_stall1    (stall_o[1]),
    .raygen_to_tarb_valid (vin[2]),
    .raygen_to_tarb_data  (din[2]),
    .raygen_to_tarb_stall (stall_o[2]),
    .tarb_to_trav_valid   (out_valid),
    .tarb_to_trav_data    (out_data),
    .tarb_to_trav_src     (out_src),
    .tarb_to_trav_stall   (down_stall),
    .busy                 (busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [WIDTH-1:0] d, input logic [1:0] s);
    chk({tag, "_valid"}, 128'(out_valid), 128'(1));
    chk({tag, "_data"}, 128'(out_data), 128'(d));
    chk({tag, "_src"}, 128'(out_src), 128'(s));
  endtask

  // One source pushes while downstream stalls: DEPTH items queue, one sits
  // in the output register, then everything drains in order.
  task automatic stall_case(input int s, input int stalled_edges, input logic [WIDTH-1:0] base);
    logic [1:0] src;
    src        = 2'(s);
    down_stall = 1'b1;
    vin[s]     = 1'b1;
    din[s]     = base;
    step();
    chk("sc_first_stall", 128'(stall_o[s]), 128'(0));
    chk("sc_first_valid", 128'(out_valid), 128'(0));
    din[s] = base + 1;
    step();
    chk_out("sc_held0", base, src);
    chk("sc_second_stall", 128'(stall_o[s]), 128'(0));
    din[s] = base + 2;
    step();
    chk("sc_full_stall", 128'(stall_o[s]), 128'(1));
    chk_out("sc_held1", base, src);
    din[s] = base + 3;
    for (int i = 0; i < stalled_edges - 3; i++) begin
      step();
      chk("sc_hold_stall", 128'(stall_o[s]), 128'(1));
      chk_out("sc_hold", base, src);
    end
    down_stall = 1'b0;
    step();
    chk_out("sc_rel0", base + 1, src);
    chk("sc_rel_stall", 128'(stall_o[s]), 128'(0));
    step();
    chk_out("sc_rel1", base + 2, src);
    vin[s] = 1'b0;
    step();
    chk_out("sc_rel2", base + 3, src);
    step();
    chk("sc_end_valid", 128'(out_valid), 128'(0));
    chk("sc_end_busy", 128'(busy), 128'(0));
  endtask

  initial begin
    logic [WIDTH-1:0] dsrc [3];
    int waited;
    din[0] = '0;
    din[1] = '0;
    din[2] = '0;

    // Reset state
    step();
    rst = 1'b1;
    #2;
    chk("rst_valid", 128'(out_valid), 128'(0));
    chk("rst_data", 128'(out_data), 128'(0));
    chk("rst_src", 128'(out_src), 128'(0));
    chk("rst_stalls", 128'(stall_o), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    step();
    rst = 1'b0;
    step();

    // Single push on source 1: output in cycle 2, busy drops in cycle 3
    vin[1] = 1'b1;
    din[1] = WIDTH'(8'hA5);
    step();
    vin[1] = 1'b0;
    chk("lat_c1_valid", 128'(out_valid), 128'(0));
    chk("lat_c1_busy", 128'(busy), 128'(1));
    step();
    chk_out("lat_c2", WIDTH'(8'hA5), 2'd1);
    step();
    chk("lat_c3_valid", 128'(out_valid), 128'(0));
    chk("lat_c3_busy", 128'(busy), 128'(0));

    // Round robin from rr=0 with all sources streaming
    rst = 1'b1;
    step();
    rst = 1'b0;
    dsrc[0] = WIDTH'(32'h1000_0000);
    dsrc[1] = WIDTH'(32'h2000_0001);
    dsrc[2] = WIDTH'(32'h3000_0002);
    din[0] = dsrc[0];
    din[1] = dsrc[1];
    din[2] = dsrc[2];
    vin    = 3'b111;
    step();
    chk("rr_c1_valid", 128'(out_valid), 128'(0));
    for (int k = 0; k < 6; k++) begin
      step();
      chk_out($sformatf("rr_k%0d", k), dsrc[k % 3], 2'(k % 3));
    end
    vin = 3'b000;
    waited = 0;
    while (busy && waited < 20) begin
      step();
      waited++;
    end
    chk("rr_drain_busy", 128'(busy), 128'(0));

    // Downstream stalled 10 cycles while source 0 pushes
    stall_case(0, 10, WIDTH'(96'h00AB_0000_0000_0000_0000_0010));
    // Source 2 full, popped with valid high: no write that cycle
    stall_case(2, 3, WIDTH'(96'h00CD_0000_0000_0000_0000_0020));

    // Reset while output is held and FIFOs hold several items
    down_stall = 1'b1;
    din[0] = WIDTH'(32'h51);
    din[1] = WIDTH'(32'h52);
    din[2] = WIDTH'(32'h53);
    vin    = 3'b111;
    step();
    step();
    vin = 3'b000;
    chk("mid_valid", 128'(out_valid), 128'(1));
    chk("mid_busy", 128'(busy), 128'(1));
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 128'(out_valid), 128'(0));
    chk("mid_rst_data", 128'(out_data), 128'(0));
    chk("mid_rst_src", 128'(out_src), 128'(0));
    chk("mid_rst_stalls", 128'(stall_o), 128'(0));
    chk("mid_rst_busy", 128'(busy), 128'(0));
    step();
    rst        = 1'b0;
    down_stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("post_rst_valid", 128'(out_valid), 128'(0));
    end

    // First edge after reset accepts normally
    rst = 1'b1;
    step();
    rst    = 1'b0;
    vin[1] = 1'b1;
    din[1] = WIDTH'(32'h77);
    step();
    vin[1] = 1'b0;
    step();
    chk_out("rel_accept", WIDTH'(32'h77), 2'd1);
    step();

    // rr forced to 3 with sources 0 and 2 pending: source 0 first, rr -> 1
    din[0] = WIDTH'(32'hE0);
    din[2] = WIDTH'(32'hE2);
    vin    = 3'b101;
    force dut.rr_reg = 2'd3;
    step();
    vin = 3'b000;
    release dut.rr_reg;
    step();
    chk_out("rr3_first", WIDTH'(32'hE0), 2'd0);
    chk("rr3_rr_after", 128'(dut.rr_reg), 128'(1));
    step();
    chk_out("rr3_second", WIDTH'(32'hE2), 2'd2);
    step();
    chk("rr3_end_busy", 128'(busy), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/trav_arb.md
TRAV_ARB -- requirements
Module: trav_arb

Interface
REQ-001 Parameter WIDTH, default 96, bit width of one tarb_t_t payload on every data port.
REQ-002 Parameter DEPTH, default 2, entries per input FIFO; legal values are 2 and 4.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 ss_to_tarb_valid0  input  1  stack-pop request valid (source 0).
REQ-006 ss_to_tarb_data0  input  WIDTH  stack-pop payload.
REQ-007 ss_to_tarb_stall0  output  1  back-pressure to source 0.
REQ-008 ss_to_tarb_valid1  input  1  restart-node request valid (source 1).
REQ-009 ss_to_tarb_data1  input  WIDTH  restart-node payload.
REQ-010 ss_to_tarb_stall1  output  1  back-pressure to source 1.
REQ-011 raygen_to_tarb_valid  input  1  new primary-ray request valid (source 2).
REQ-012 raygen_to_tarb_data  input  WIDTH  primary-ray payload.
REQ-013 raygen_to_tarb_stall  output  1  back-pressure to source 2.
REQ-014 tarb_to_trav_valid  output  1  arbitrated request valid.
REQ-015 tarb_to_trav_data  output  WIDTH  arbitrated payload.
REQ-016 tarb_to_trav_src  output  2  source index of the current output: 0, 1 or 2.
REQ-017 tarb_to_trav_stall  input  1  downstream back-pressure.
REQ-018 busy  output  1  high when any FIFO is non-empty or tarb_to_trav_valid is high.

Function
REQ-019 Each source i SHALL feed a private DEPTH-entry FIFO, and a transfer SHALL occur when valid_i=1 and stall_i=0 in the same cycle.
REQ-020 stall_i SHALL equal FIFO_i full, derived only from registered occupancy and with no combinational path from any valid or downstream stall.
REQ-021 A full FIFO SHALL NOT accept a write in the same cycle it is read (no bypass); stall_i deasserts the cycle after occupancy drops.
REQ-022 Payload SHALL pass unmodified, and per-source order SHALL be preserved.
REQ-023 The output stage SHALL be a single register (tarb_to_trav_valid/data/src) that may load when tarb_to_trav_valid=0 or tarb_to_trav_stall=0.
REQ-024 A 2-bit round-robin pointer rr SHALL select source priority order rr, rr+1, rr+2 (mod 3) among non-empty FIFOs.
REQ-025 At most one grant SHALL occur per cycle, only when the output may load; the granted FIFO is popped and its head is loaded into the output register.
REQ-026 On a grant to source g, rr SHALL become (g+1) mod 3; with no grant, rr SHALL hold.
REQ-027 An rr value of 3 SHALL be treated as 0 for priority and SHALL be corrected to a legal value on the next update.
REQ-028 While tarb_to_trav_valid=1 and tarb_to_trav_stall=1, the output data and src SHALL remain stable and no FIFO SHALL be popped.
REQ-029 Minimum latency SHALL be 2 cycles: accepted at edge N, FIFO non-empty in cycle N+1, output valid in cycle N+2.
REQ-030 Throughput SHALL be one request per cycle with tarb_to_trav_stall=0 and any FIFO non-empty.
REQ-031 A push and pop on the same non-full FIFO in one cycle SHALL leave occupancy unchanged.
REQ-032 With a single source active, every grant SHALL go to that source with no idle cycles.
REQ-033 No source SHALL wait more than 2 grants once its FIFO is non-empty.

Reset
REQ-034 Asserting rst SHALL immediately empty all FIFOs and set rr=0, tarb_to_trav_valid=0, tarb_to_trav_data=0, tarb_to_trav_src=0, all stall outputs 0 and busy=0.
REQ-035 Reset asserted mid-transfer SHALL discard all buffered and output-held requests; none SHALL be emitted after reset release.
REQ-036 The first edge after rst deasserts SHALL accept inputs normally.

Verification
REQ-037 Idle, single push on source 1 with data 0xA5 at cycle 0 -> valid=1, data=0xA5, src=1 in cycle 2; busy falls in cycle 3.
REQ-038 All three sources hold valid continuously from rr=0 with downstream never stalled -> src sequence 0,1,2,0,1,2 with no bubbles.
REQ-039 tarb_to_trav_stall=1 for 10 cycles while source 0 pushes -> source 0 stall=1 after DEPTH accepted plus 1 held; output unchanged throughout; all items emitted in order after release.
REQ-040 Source 2 FIFO full with simultaneous pop and valid -> no write that cycle; stall2 low the next cycle; no item lost or duplicated.
REQ-041 rst pulsed while output valid=1, stalled, and FIFOs holding 3 items -> all outputs 0 immediately; nothing emitted after release.
REQ-042 rr forced to 3 with sources 0 and 2 pending -> source 0 granted first, and rr=1 afterwards.
